// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the TX path),
// default frame constants and the parity helper.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Expected parity bit for a data word (zero-extended to 8 bits).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// UART RX sampler: 2-flop synchroniser, oversample tick counter and the
// bit-decision strobe for the receive FSM.
// Build option: UART_RX_MAJORITY_EN enables a 3-sample majority vote
// around mid-bit; otherwise a single sample is taken at mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clock,
  input  logic reset,
  input  logic rx_serial,
  input  logic sample_tick,
  input  logic idle,
  input  logic in_start,
  output logic rx_s,
  output logic bit_sample,
  output logic sample_strobe
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MID_LAST = OVERSAMPLE / 2;
`else
  localparam int unsigned MID_LAST = OVERSAMPLE / 2 - 1;
`endif
  localparam int unsigned FULL_LAST = OVERSAMPLE - 1;

  logic          rx_meta;
  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] last_cnt;

  // Start bit decides at mid-bit; every later bit decides one full period on.
  always_comb begin
    last_cnt      = in_start ? CW'(MID_LAST) : CW'(FULL_LAST);
    sample_strobe = sample_tick && !idle && (tick_cnt == last_cnt);
  end

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // Tick counter: held at zero in IDLE, restarts after every bit decision.
  always_ff @(posedge clock) begin
    if (reset || idle || sample_strobe) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote0;
  logic vote1;

  // Capture the two samples preceding the decision tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      vote0 <= 1'b1;
      vote1 <= 1'b1;
    end else if (sample_tick && !idle) begin
      if (tick_cnt == last_cnt - CW'(2)) vote0 <= rx_s;
      if (tick_cnt == last_cnt - CW'(1)) vote1 <= rx_s;
    end
  end

  // Majority of the two captured samples and the current one.
  always_comb begin
    bit_sample = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);
  end
`else
  // Single mid-bit sample.
  always_comb begin
    bit_sample = rx_s;
  end
`endif

endmodule

// File: rtl/uart_rx_controlpath.sv
// UART receiver: start detection, LSB-first data shift, parity/stop check
// and a valid/ready holding register for the received byte.
// Build option: UART_RX_MAJORITY_EN (majority-vote sampling in the sampler).
module uart_rx_controlpath
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 sample_tick,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS);

  logic [2:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [7:0]           data_ext;
  logic                 par_bad_q;
  logic                 stop_q;
  logic                 done_q;
  logic                 rx_s;
  logic                 bit_sample;
  logic                 sample_strobe;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clock        (clock),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .sample_tick  (sample_tick),
    .idle         (state == IDLE),
    .in_start     (state == START),
    .rx_s         (rx_s),
    .bit_sample   (bit_sample),
    .sample_strobe(sample_strobe)
  );

  // Zero-extend the shifted word for the parity helper and flag the FSM state.
  always_comb begin
    data_ext                = '0;
    data_ext[DATA_BITS-1:0] = shreg;
    busy                    = (state != IDLE);
  end

  // Receive FSM; done_q marks the clock after the stop-bit decision.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad_q <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end
        START: begin
          if (sample_strobe) begin
            bit_cnt <= '0;
            state   <= bit_sample ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sample_strobe) begin
            shreg   <= {bit_sample, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= PARITY;
          end
        end
        PARITY: begin
          if (sample_strobe) begin
            par_bad_q <= (bit_sample != parity_bit(data_ext, 1'(PARITY_ODD)));
            state     <= STOP;
          end
        end
        STOP: begin
          // Leave at mid-stop so the next start edge is not missed.
          if (sample_strobe) begin
            stop_q <= bit_sample;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: load on completion if free (or being freed), else overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_bad_q;
          frame_err  <= !stop_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controlpath.sv
// Directed bench for uart_rx_controlpath: 16 ticks/bit, sample_tick every
// second clock (32 clocks per bit). A second instance with odd parity shares
// the serial line.
module tb_uart_rx_controlpath;

  localparam int unsigned BITCLK = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic       sample_tick = 1'b0;
  logic       rx_ready;
  logic       odd_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;
  logic [7:0] odd_data;
  logic       odd_valid, odd_perr, odd_ferr, odd_overrun, odd_busy;

  int errors = 0;
  int checks = 0;

  // Monitor results
  int         valid_cnt, ovr_cnt, odd_valid_cnt;
  logic [7:0] cap_data;
  logic       cap_perr, cap_ferr, odd_cap_perr;
  logic       prev_valid = 1'b0, odd_prev_valid = 1'b0;

  uart_rx_controlpath #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)
  ) dut (
    .clock(clock), .reset(reset), .rx_serial(rx_serial), .sample_tick(sample_tick),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_controlpath #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(1)
  ) dut_odd (
    .clock(clock), .reset(reset), .rx_serial(rx_serial), .sample_tick(sample_tick),
    .rx_ready(odd_ready), .rx_data(odd_data), .rx_valid(odd_valid),
    .parity_err(odd_perr), .frame_err(odd_ferr), .overrun(odd_overrun), .busy(odd_busy)
  );

  initial forever #5 clock = ~clock;
  initial forever begin
    @(negedge clock);
    sample_tick = ~sample_tick;
  end

  // Record rising edges of rx_valid with their payload, and overrun cycles.
  always @(posedge clock) begin
    #1;
    if (rx_valid && !prev_valid) begin
      valid_cnt = valid_cnt + 1;
      cap_data  = rx_data;
      cap_perr  = parity_err;
      cap_ferr  = frame_err;
    end
    prev_valid = rx_valid;
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (odd_valid && !odd_prev_valid) begin
      odd_valid_cnt = odd_valid_cnt + 1;
      odd_cap_perr  = odd_perr;
    end
    odd_prev_valid = odd_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    valid_cnt = 0; ovr_cnt = 0; odd_valid_cnt = 0;
    cap_data = 8'hxx; cap_perr = 1'bx; cap_ferr = 1'bx; odd_cap_perr = 1'bx;
  endtask

  task automatic idle_clks(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, input int unsigned clks);
    rx_serial = b;
    idle_clks(clks);
  endtask

  task automatic send_head(input logic [7:0] d, input int unsigned nbits);
    send_bit(1'b0, BITCLK);
    for (int i = 0; i < int'(nbits); i++) send_bit(d[i], BITCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int unsigned stop_clks);
    send_head(d, 8);
    send_bit(par, BITCLK);
    send_bit(stp, stop_clks);
    rx_serial = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_serial = 1'b1; rx_ready = 1'b1; odd_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clock);
    reset = 1'b0;
    idle_clks(10);
  endtask

  task automatic test_basic();
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, BITCLK);
    idle_clks(40);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL basic_valid_cnt got=%0d exp=1", valid_cnt); end
    checks++; if (cap_data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", cap_data); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL basic_perr got=%b exp=0", cap_perr); end
    checks++; if (cap_ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", cap_ferr); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed got=%b exp=0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", busy); end
    checks++; if (odd_cap_perr !== 1'b1) begin errors++; $display("FAIL basic_odd_perr got=%b exp=1", odd_cap_perr); end
  endtask

  task automatic test_parity();
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b1, BITCLK);
    idle_clks(40);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL par_valid_cnt got=%0d exp=1", valid_cnt); end
    checks++; if (cap_data !== 8'h3C) begin errors++; $display("FAIL par_data got=%h exp=3c", cap_data); end
    checks++; if (cap_perr !== 1'b1) begin errors++; $display("FAIL par_even_perr got=%b exp=1", cap_perr); end
    checks++; if (cap_ferr !== 1'b0) begin errors++; $display("FAIL par_ferr got=%b exp=0", cap_ferr); end
    checks++; if (odd_valid_cnt !== 1) begin errors++; $display("FAIL par_odd_valid_cnt got=%0d exp=1", odd_valid_cnt); end
    checks++; if (odd_cap_perr !== 1'b0) begin errors++; $display("FAIL par_odd_perr got=%b exp=0", odd_cap_perr); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    rx_ready = 1'b0;
    // Stop bit low for 3/4 of a bit: sampled low at mid-bit, high again well
    // before the spurious start (caused by the low stop) reaches its mid-sample.
    send_frame(8'h55, 1'b0, 1'b0, 24);
    idle_clks(80);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ferr_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL ferr_data got=%h exp=55", rx_data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL ferr_no_overrun got=%0d exp=0", ovr_cnt); end
    rx_ready = 1'b1;
    idle_clks(4);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
    clear_mon();
    send_frame(8'h01, 1'b1, 1'b1, BITCLK);
    idle_clks(40);
    checks++; if (cap_data !== 8'h01) begin errors++; $display("FAIL ferr_next_data got=%h exp=01", cap_data); end
    checks++; if (cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin
      errors++; $display("FAIL ferr_next_flags got=%b%b exp=00", cap_perr, cap_ferr);
    end
  endtask

  task automatic test_false_start();
    logic dropped;
    clear_mon();
    send_bit(1'b0, 8);
    rx_serial = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", busy); end
    dropped = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (busy === 1'b0) begin dropped = 1'b1; break; end
    end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL glitch_busy_drop got=busy_high exp=idle_within_8_ticks"); end
    idle_clks(400);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_cnt); end
  endtask

  task automatic test_overrun();
    logic seen;
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, BITCLK);
    send_frame(8'h22, 1'b0, 1'b1, BITCLK);
    idle_clks(40);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt); end
    clear_mon();
    send_head(8'h33, 8);
    send_bit(1'b0, BITCLK);
    rx_serial = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (dut.done_q === 1'b1) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ovr_completion got=none exp=frame_done_within_64"); end
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL ovr_replace_data got=%h exp=33", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_replace_valid got=%b exp=1", rx_valid); end
    idle_clks(20);
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL ovr_none got=%0d exp=0", ovr_cnt); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_consumed got=%b exp=0", rx_valid); end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    rx_ready = 1'b0;
    send_head(8'hFF, 4);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
    checks++; if ({rx_valid, parity_err, frame_err, overrun} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got=%b exp=0000", {rx_valid, parity_err, frame_err, overrun});
    end
    @(negedge clock);
    reset = 1'b0;
    rx_serial = 1'b1;
    idle_clks(200);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", valid_cnt); end
    rx_ready = 1'b1;
    send_frame(8'h80, 1'b1, 1'b1, BITCLK);
    idle_clks(40);
    checks++; if (cap_data !== 8'h80) begin errors++; $display("FAIL rstmid_next_data got=%h exp=80", cap_data); end
    checks++; if (cap_perr !== 1'b0) begin errors++; $display("FAIL rstmid_next_perr got=%b exp=0", cap_perr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_controlpath.md
Name: uart_rx_controlpath

Overview:
UART receiver for the serial line driven by the team's TX path; it sits directly downstream of the TX stage.
- Oversamples the synchronised rx line on a baud-rate strobe and detects the start bit.
- Shifts in data LSB-first, checks parity and stop, and presents the byte through a valid/ready holding register.
- Frame format matches TX: 1 start bit, DATA_BITS data bits, 1 parity bit, 1 stop bit.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=8)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
rx_serial  input  1  asynchronous serial line; idles high
sample_tick  input  1  one-clock strobe at OVERSAMPLE x baud rate
rx_ready  input  1  consumer accepts the held byte when high with rx_valid
rx_data  output  DATA_BITS  received byte
rx_valid  output  1  rx_data is held and unconsumed
parity_err  output  1  parity mismatch on the byte currently held
frame_err  output  1  stop bit sampled low on the byte currently held
overrun  output  1  one-clock pulse: a completed frame was dropped
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset, sampled on a clock edge with reset=1:
  - Synchroniser flops go to 1, FSM to IDLE, tick and bit counters to 0, shift register to 0.
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame abandons the frame; no rx_valid results from it.
- rx_serial passes through a 2-flop synchroniser; rx_s below means the synchronised value.
- The FSM and tick counter advance only on clocks where sample_tick=1, except the IDLE exit.
- FSM states and transitions:
  - IDLE: when rx_s=0 on any clock, go to START and clear the tick counter.
  - START: count ticks. On tick number OVERSAMPLE/2 (mid-bit), sample rx_s.
    - Sample 1: false start; return to IDLE with no flags changed.
    - Sample 0: clear the tick counter and go to DATA.
  - DATA: sample on every OVERSAMPLE-th tick and shift right into the shift register (LSB first). After DATA_BITS samples, go to PARITY.
  - PARITY: sample after OVERSAMPLE ticks. Mismatch = (XOR of the data bits XOR sample) != PARITY_ODD.
  - STOP: sample after OVERSAMPLE ticks, then complete the frame and return to IDLE at mid-stop-bit, so the next start edge is caught.
- Frame completion, in the clock after the STOP sample tick:
  - If rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, parity_err and frame_err (frame_err = stop sample==0), and set rx_valid=1.
  - Else: keep the old byte and flags, and pulse overrun for 1 clock.
- Handshake:
  - When rx_valid=1 and rx_ready=1 with no completion that cycle: rx_valid goes 0 next clock. parity_err and frame_err clear with it.
  - rx_data holds its last value.
- sample_tick=1 on consecutive clocks is legal; each clock counts one tick.
- busy = (state != IDLE).

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit sample is a majority vote of rx_s captured at mid-bit ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Each state's decision moves one tick later; the IDLE return in STOP happens after the third sample.
- Undefined: single sample at tick OVERSAMPLE/2, and no extra flops.

Decomposition:
- Package uart_pkg holds:
  - state enum constants IDLE/START/DATA/PARITY/STOP (3-bit encodings shared with TX);
  - the default DATA_BITS and OVERSAMPLE constants;
  - a parity function (data, odd) -> expected bit.
- One sub-module, uart_rx_sampler: the synchroniser, tick counter and (optional) majority voter. It outputs bit_sample and a sample_strobe pulse to the FSM.

Test Plan:
- Byte 0xA5, even parity (bit 0), stop 1, 16 ticks/bit, rx_ready tied 1 -> rx_valid pulses once, rx_data=0xA5, parity_err=0, frame_err=0.
- 0x3C sent with parity bit 1 (wrong for even) -> rx_data=0x3C, parity_err=1, frame_err=0. Same frame with PARITY_ODD=1 -> parity_err=0.
- 0x55 with stop bit driven 0 -> rx_valid=1, frame_err=1. Line then held high -> FSM returns to IDLE and the next frame 0x01 is received cleanly.
- Glitch low for 4 ticks, then high -> false start, busy drops within 8 ticks, rx_valid stays 0.
- rx_ready=0 across two frames 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses 1 clock. Then with rx_ready=1 on the completion clock of a third frame 0x33 -> rx_data=0x33 and no overrun.
- Reset asserted for 1 clock after data bit 3 of 0xFF -> all outputs 0 next clock. A following clean frame 0x80 gives rx_data=0x80.
